rice_fifo_feeder: RTL

- Read-side controller for the 32-bit telemetry word FIFO.
- Pops compressed words from the FIFO, packs them MSB-first into a 64-bit bit buffer, and presents a 32-bit peek window to the Rice decoder.
- The decoder consumes a variable number of bits (1..32) per cycle.
- Sequences one packet at a time: start, fetch, drain, done. Supports an abort (flush).

---
 rtl/rice_fifo_feeder.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rice_fifo_feeder.sv
// Read-side controller for the telemetry word FIFO: pops 32-bit words into a
// 64-bit MSB-first bit buffer and exposes a 32-bit peek window to the Rice decoder.
module rice_fifo_feeder #(
  parameter int DW    = 32,
  parameter int LEN_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_pkt_words,
  input  logic             i_flush,
  input  logic             i_fifo_empty,
  input  logic [DW-1:0]    i_fifo_dout,
  output logic             o_fifo_rd_en,
  output logic [31:0]      o_peek_data,
  output logic [6:0]       o_bits_avail,
  input  logic             i_consume,
  input  logic [5:0]       i_consume_n,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_err
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t              r_state;
  logic [2*DW-1:0]     r_buf;
  logic [6:0]          r_bits;
  logic [LEN_W-1:0]    r_words_left;
  logic                r_rd_pend;
  logic                r_done;
  logic                r_err;

  logic                w_active;
  logic [7:0]          w_fill;
  logic                w_legal;
  logic                w_bad;
  logic [6:0]          w_n;
  logic [6:0]          w_c;
  logic [2*DW-1:0]     w_shifted;
  logic [2*DW-1:0]     w_append;
  logic [2*DW-1:0]     w_buf_next;
  logic [6:0]          w_bits_next;

  assign w_active = (r_state != S_IDLE);

  // Counting the in-flight word keeps c+32 <= 64 at append time, so no overflow.
  assign w_fill       = {1'b0, r_bits} + (r_rd_pend ? 8'd32 : 8'd0);
  assign o_fifo_rd_en = (r_state == S_RUN) && !i_fifo_empty &&
                        (r_words_left != '0) && (w_fill <= 8'd32);

  assign w_legal = (i_consume_n != 6'd0) && (i_consume_n <= 6'd32) &&
                   ({1'b0, i_consume_n} <= r_bits);
  assign w_bad   = w_active && i_consume && !w_legal;
  assign w_n     = (w_active && i_consume && w_legal) ? {1'b0, i_consume_n} : 7'd0;

  assign w_c         = r_bits - w_n;
  assign w_shifted   = r_buf << w_n;
  assign w_append    = {i_fifo_dout, {DW{1'b0}}} >> w_c;
  assign w_buf_next  = r_rd_pend ? (w_shifted | w_append) : w_shifted;
  assign w_bits_next = r_rd_pend ? (w_c + 7'd32) : w_c;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_buf        <= '0;
      r_bits       <= '0;
      r_words_left <= '0;
      r_rd_pend    <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else if (w_active && i_flush) begin
      r_state      <= S_IDLE;
      r_buf        <= '0;
      r_bits       <= '0;
      r_words_left <= '0;
      r_rd_pend    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_rd_pend <= 1'b0;
          if (i_start) begin
            r_words_left <= i_pkt_words;
            r_buf        <= '0;
            r_bits       <= '0;
            r_err        <= 1'b0;
            r_state      <= (i_pkt_words == '0) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN, S_DRAIN: begin
          r_buf     <= w_buf_next;
          r_bits    <= w_bits_next;
          r_rd_pend <= o_fifo_rd_en;
          if (o_fifo_rd_en) r_words_left <= r_words_left - LEN_W'(1);
          if (w_bad) r_err <= 1'b1;
          if (r_state == S_RUN) begin
            if ((r_words_left == '0) && !r_rd_pend) r_state <= S_DRAIN;
          end else if (w_c == 7'd0) begin
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_peek_data  = r_buf[2*DW-1 -: 32];
  assign o_bits_avail = r_bits;
  assign o_busy       = w_active;
  assign o_done       = r_done;
  assign o_err        = r_err;

endmodule
